// File: rtl/srl_fifo_pkg.sv
// rtl/srl_fifo_pkg.sv - shared limits and sizing helpers for the shift-register FIFO cell
package srl_fifo_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;
    localparam int DEPTH_MIN = 4;
    localparam int DEPTH_MAX = 32;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

    function automatic int capacity(input int depth, input int oreg_en);
        return depth + ((oreg_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/srl_stage_chain.sv
// rtl/srl_stage_chain.sv - DEPTH x WIDTH shift array, newest entry at stage 0
module srl_stage_chain
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic [WIDTH-1:0]         shift_in,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (shift_en) begin
            stage[0] <= shift_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign rd_data = stage[rd_addr];

endmodule

// File: rtl/srl_fifo_cell.sv
// rtl/srl_fifo_cell.sv - whitebox shift-register FIFO with optional registered head stage
(* whitebox *)
module srl_fifo_cell
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16,
    (* fasm *) parameter int OREG_EN = 0,
    (* fasm *) parameter int AFULL_THRESH = 12
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [WIDTH-1:0]              D,
    input  logic                          PUSH,
    input  logic                          POP,
    output logic [WIDTH-1:0]              Q,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic                          AFULL,
    output logic [level_width(DEPTH)-1:0] LEVEL
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int LW  = level_width(DEPTH);
    localparam int AW  = $clog2(DEPTH);
    localparam int CAP = capacity(DEPTH, OREG_EN);
    localparam bit OREG = (OREG_EN != 0);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("srl_fifo_cell: WIDTH out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("srl_fifo_cell: DEPTH must be 4, 8, 16 or 32");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > CAP) begin : g_bad_thresh
        $error("srl_fifo_cell: AFULL_THRESH out of range");
    end

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             hv;
    logic [WIDTH-1:0] hreg;
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    rd_addr;
    logic [LW-1:0]    level;
    logic             pop_acc;
    logic             push_acc;
    logic             refill;

    // Flags decode from cnt/hv only, so no input reaches an output combinationally.
    always_comb begin
        level    = LW'(cnt) + LW'(hv);
        EMPTY    = OREG ? !hv : (cnt == '0);
        FULL     = (level == LW'(CAP));
        AFULL    = (level >= LW'(AFULL_THRESH));
        pop_acc  = POP && !EMPTY;
        push_acc = PUSH && (!FULL || pop_acc);
        refill   = OREG && (cnt != '0) && (!hv || pop_acc);
        cnt_nxt  = cnt + CW'(push_acc) - CW'(OREG ? refill : pop_acc);
    end

    // cnt==0 wraps to the top stage; Q is meaningless then, and that stage is zero after reset.
    assign rd_addr = AW'(cnt - CW'(1));

    srl_stage_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chain (
        .clk      (CLK),
        .rst_n    (RST_N),
        .shift_en (push_acc),
        .shift_in (D),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            hv   <= 1'b0;
            hreg <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (refill) begin
                hreg <= rd_data;
                hv   <= 1'b1;
            end else if (pop_acc) begin
                hv <= 1'b0;
            end
        end
    end

    assign Q     = OREG ? hreg : rd_data;
    assign LEVEL = level;

endmodule

// File: tb/tb_srl_fifo_cell.sv
// tb/tb_srl_fifo_cell.sv - randomized queue-model bench over three FIFO configurations
module tb_srl_fifo_cell;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       push_s  [3];
    logic       pop_s   [3];
    logic [3:0] d_s     [3];
    logic [3:0] q_s     [3];
    logic       empty_s [3];
    logic       full_s  [3];
    logic       afull_s [3];
    logic [5:0] level0;
    logic [3:0] level1;
    logic [4:0] level2;

    int errors = 0;
    int checks = 0;

    // Model: instance 0 = D16/no oreg/th12, 1 = D4/oreg/th3, 2 = D8/no oreg/th1
    int mq [3][$];
    bit hv_m   [3];
    int hval_m [3];
    int cap_m  [3] = '{16, 5, 8};
    int th_m   [3] = '{12, 3, 1};
    bit oreg_m [3] = '{1'b0, 1'b1, 1'b0};

    srl_fifo_cell #(.WIDTH(4), .DEPTH(16), .OREG_EN(0), .AFULL_THRESH(12)) u_d16 (
        .CLK(clk), .RST_N(rst_n), .D(d_s[0]), .PUSH(push_s[0]), .POP(pop_s[0]),
        .Q(q_s[0]), .EMPTY(empty_s[0]), .FULL(full_s[0]), .AFULL(afull_s[0]), .LEVEL(level0));

    srl_fifo_cell #(.WIDTH(4), .DEPTH(4), .OREG_EN(1), .AFULL_THRESH(3)) u_d4_oreg (
        .CLK(clk), .RST_N(rst_n), .D(d_s[1]), .PUSH(push_s[1]), .POP(pop_s[1]),
        .Q(q_s[1]), .EMPTY(empty_s[1]), .FULL(full_s[1]), .AFULL(afull_s[1]), .LEVEL(level1));

    srl_fifo_cell #(.WIDTH(4), .DEPTH(8), .OREG_EN(0), .AFULL_THRESH(1)) u_d8_th1 (
        .CLK(clk), .RST_N(rst_n), .D(d_s[2]), .PUSH(push_s[2]), .POP(pop_s[2]),
        .Q(q_s[2]), .EMPTY(empty_s[2]), .FULL(full_s[2]), .AFULL(afull_s[2]), .LEVEL(level2));

    function automatic int dut_level(input int k);
        case (k)
            0:       return int'(level0);
            1:       return int'(level1);
            default: return int'(level2);
        endcase
    endfunction

    function automatic int exp_level(input int k);
        return mq[k].size() + ((oreg_m[k] && hv_m[k]) ? 1 : 0);
    endfunction

    function automatic bit exp_empty(input int k);
        return oreg_m[k] ? !hv_m[k] : (mq[k].size() == 0);
    endfunction

    function automatic int exp_q(input int k);
        if (oreg_m[k]) return hval_m[k];
        return (mq[k].size() > 0) ? mq[k][0] : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            hv_m[k]   = 1'b0;
            hval_m[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int lvl = exp_level(k);
            bit pa  = pop_s[k] && !exp_empty(k);
            bit pu  = push_s[k] && ((lvl != cap_m[k]) || pa);
            if (oreg_m[k]) begin
                if (mq[k].size() > 0 && (!hv_m[k] || pa)) begin
                    hval_m[k] = mq[k].pop_front();
                    hv_m[k]   = 1'b1;
                end else if (pa) begin
                    hv_m[k] = 1'b0;
                end
            end else if (pa) begin
                void'(mq[k].pop_front());
            end
            if (pu) mq[k].push_back(int'(d_s[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            push_s[k] = 1'b0;
            pop_s[k]  = 1'b0;
            d_s[k]    = 4'h0;
        end
    endtask

    task automatic drive(input int k, input bit pu, input bit po, input logic [3:0] d);
        push_s[k] = pu;
        pop_s[k]  = po;
        d_s[k]    = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (empty_s[k] !== 1'b1 || full_s[k] !== 1'b0 || afull_s[k] !== 1'b0 ||
                dut_level(k) != 0 || q_s[k] !== 4'h0) begin
                errors++;
                $display("FAIL reset_state k=%0d got e=%b f=%b af=%b lvl=%0d q=%h exp e=1 f=0 af=0 lvl=0 q=0",
                         k, empty_s[k], full_s[k], afull_s[k], dut_level(k), q_s[k]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_level(k) != 0 || empty_s[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release k=%0d got lvl=%0d e=%b exp lvl=0 e=1", k, dut_level(k), empty_s[k]);
            end
        end
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b0, 4'(i));
            step();
            checks++;
            if (level0 != 6'(i + 1) || afull_s[0] !== (i + 1 >= 12) || full_s[0] !== (i + 1 == 16)) begin
                errors++;
                $display("FAIL fill i=%0d got lvl=%0d af=%b f=%b exp lvl=%0d af=%b f=%b",
                         i, level0, afull_s[0], full_s[0], i + 1, (i + 1 >= 12), (i + 1 == 16));
            end
        end
        drive(0, 1'b1, 1'b0, 4'h9);
        step();
        checks++;
        if (level0 != 6'd16 || full_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL push_at_full got lvl=%0d f=%b exp lvl=16 f=1", level0, full_s[0]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_s[0] !== 4'(i) || empty_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL drain_q i=%0d got q=%h e=%b exp q=%h e=0", i, q_s[0], empty_s[0], 4'(i));
            end
            drive(0, 1'b0, 1'b1, 4'h0);
            step();
        end
        idle();
        checks++;
        if (empty_s[0] !== 1'b1 || level0 != 6'd0) begin
            errors++;
            $display("FAIL drain_empty got e=%b lvl=%0d exp e=1 lvl=0", empty_s[0], level0);
        end
    endtask

    task automatic test_full_push_pop();
        int exp_seq[$];
        idle();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b0, 4'(i));
            step();
        end
        drive(0, 1'b1, 1'b1, 4'h5);
        step();
        checks++;
        if (level0 != 6'd16 || full_s[0] !== 1'b1 || q_s[0] !== 4'h1) begin
            errors++;
            $display("FAIL full_push_pop got lvl=%0d f=%b q=%h exp lvl=16 f=1 q=1", level0, full_s[0], q_s[0]);
        end
        for (int i = 1; i < 16; i++) exp_seq.push_back(i);
        exp_seq.push_back(5);
        foreach (exp_seq[i]) begin
            checks++;
            if (q_s[0] !== 4'(exp_seq[i])) begin
                errors++;
                $display("FAIL full_pp_drain i=%0d got q=%h exp q=%h", i, q_s[0], 4'(exp_seq[i]));
            end
            drive(0, 1'b0, 1'b1, 4'h0);
            step();
        end
        idle();
        checks++;
        if (empty_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_empty got e=%b exp e=1", empty_s[0]);
        end
    endtask

    task automatic test_empty_corners();
        idle();
        drive(0, 1'b0, 1'b1, 4'h0);
        step();
        checks++;
        if (level0 != 6'd0 || empty_s[0] !== 1'b1 || full_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty got lvl=%0d e=%b f=%b exp lvl=0 e=1 f=0", level0, empty_s[0], full_s[0]);
        end
        drive(0, 1'b1, 1'b1, 4'hA);
        step();
        checks++;
        if (level0 != 6'd1 || empty_s[0] !== 1'b0 || q_s[0] !== 4'hA) begin
            errors++;
            $display("FAIL push_pop_empty got lvl=%0d e=%b q=%h exp lvl=1 e=0 q=a", level0, empty_s[0], q_s[0]);
        end
        drive(0, 1'b0, 1'b1, 4'h0);
        step();
        idle();
    endtask

    task automatic test_oreg();
        idle();
        drive(1, 1'b1, 1'b0, 4'h3);
        step();
        idle();
        checks++;
        if (empty_s[1] !== 1'b1 || level1 != 4'd1) begin
            errors++;
            $display("FAIL oreg_lat1 got e=%b lvl=%0d exp e=1 lvl=1", empty_s[1], level1);
        end
        step();
        checks++;
        if (empty_s[1] !== 1'b0 || q_s[1] !== 4'h3 || level1 != 4'd1) begin
            errors++;
            $display("FAIL oreg_lat2 got e=%b q=%h lvl=%0d exp e=0 q=3 lvl=1", empty_s[1], q_s[1], level1);
        end
        for (int i = 4; i < 8; i++) begin
            drive(1, 1'b1, 1'b0, 4'(i));
            step();
        end
        drive(1, 1'b1, 1'b0, 4'hE);
        step();
        checks++;
        if (level1 != 4'd5 || full_s[1] !== 1'b1 || afull_s[1] !== 1'b1) begin
            errors++;
            $display("FAIL oreg_full got lvl=%0d f=%b af=%b exp lvl=5 f=1 af=1", level1, full_s[1], afull_s[1]);
        end
        for (int i = 3; i < 8; i++) begin
            checks++;
            if (q_s[1] !== 4'(i) || empty_s[1] !== 1'b0) begin
                errors++;
                $display("FAIL oreg_drain got q=%h e=%b exp q=%h e=0", q_s[1], empty_s[1], 4'(i));
            end
            drive(1, 1'b0, 1'b1, 4'h0);
            step();
        end
        idle();
        checks++;
        if (empty_s[1] !== 1'b1 || level1 != 4'd0) begin
            errors++;
            $display("FAIL oreg_drained got e=%b lvl=%0d exp e=1 lvl=0", empty_s[1], level1);
        end
    endtask

    task automatic test_afull_one();
        idle();
        for (int n = 0; n < 150; n++) begin
            drive(2, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), 4'($urandom));
            step();
            checks++;
            if (afull_s[2] !== !empty_s[2] || afull_s[2] !== (exp_level(2) >= 1) || dut_level(2) != exp_level(2)) begin
                errors++;
                $display("FAIL afull_th1 n=%0d got af=%b e=%b lvl=%0d exp af=%b lvl=%0d",
                         n, afull_s[2], empty_s[2], dut_level(2), (exp_level(2) >= 1), exp_level(2));
            end
        end
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            int bias = (n % 100 < 50) ? 75 : 30;
            for (int k = 0; k < 3; k++)
                drive(k, ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 100 - bias), 4'($urandom));
            step();
            for (int k = 0; k < 3; k++) begin
                int  el = exp_level(k);
                bit  ee = exp_empty(k);
                checks++;
                if (dut_level(k) != el || empty_s[k] !== ee || full_s[k] !== (el == cap_m[k]) ||
                    afull_s[k] !== (el >= th_m[k]) || (!ee && q_s[k] !== 4'(exp_q(k)))) begin
                    errors++;
                    $display("FAIL random n=%0d k=%0d got lvl=%0d e=%b f=%b af=%b q=%h exp lvl=%0d e=%b f=%b af=%b q=%h",
                             n, k, dut_level(k), empty_s[k], full_s[k], afull_s[k], q_s[k],
                             el, ee, (el == cap_m[k]), (el >= th_m[k]), 4'(exp_q(k)));
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 1'b0, 4'(i + 8));
            drive(1, 1'b1, 1'b0, 4'(i + 1));
            step();
        end
        idle();
        checks++;
        if (level0 < 6'd5) begin
            errors++;
            $display("FAIL mid_prefill got lvl=%0d exp lvl>=5", level0);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (empty_s[k] !== 1'b1 || full_s[k] !== 1'b0 || afull_s[k] !== 1'b0 ||
                dut_level(k) != 0 || q_s[k] !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got e=%b f=%b af=%b lvl=%0d q=%h exp e=1 f=0 af=0 lvl=0 q=0",
                         k, empty_s[k], full_s[k], afull_s[k], dut_level(k), q_s[k]);
            end
        end
        step();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 4'hC);
        step();
        idle();
        checks++;
        if (level0 != 6'd1 || q_s[0] !== 4'hC || level1 != 4'd0 || level2 != 5'd0) begin
            errors++;
            $display("FAIL post_reset_push got lvl0=%0d q0=%h lvl1=%0d lvl2=%0d exp 1 c 0 0",
                     level0, q_s[0], level1, level2);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_empty_corners();
        test_oreg();
        test_afull_one();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
